aes_round_ctrl: RTL
===================

# aes_round_ctrl

Sequencing controller for the iterative AES encryption core. It accepts a block and load request, registers the plaintext into `text_in_r`, and pulses `ld_r`/`kld` so the add-round-key stage and key expander load their initial state. It then steps the round counter that drives the round datapath and key schedule, flags the final round (MixColumns bypass), and holds the result valid under a valid/ready handshake. It sits between the core's host interface and the state-array/round-key datapath.

## Interface
- No HDL parameters; round count is fixed per build, see Configuration.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to encrypt `text_in`; honoured only when `busy`=0 or in the same cycle as an output handshake.
- `text_in`  in  128  plaintext block, sampled on an accepted `start`.
- `key_len`  in  2  0=128, 1=192, 2=256, 3=reserved (treated as 128); exists only with `AES_KEYLEN_SEL_EN`.
- `out_ready`  in  1  downstream accepts the result.
- `text_in_r`  out  128  registered plaintext, stable from the accept cycle until the next accept.
- `ld_r`  out  1  one-cycle load strobe to the add-round-key stage (initial XOR with round key 0).
- `kld`  out  1  one-cycle key-expander load; coincident with `ld_r`.
- `round_idx`  out  4  current round number 1..Nr; 0 outside the round phase.
- `round_en`  out  1  datapath advances one round this cycle.
- `last_round`  out  1  `round_en` cycle with `round_idx`==Nr; selects MixColumns bypass.
- `busy`  out  1  block in flight (LOAD, ROUND or HOLD).
- `out_valid`  out  1  result in the state array is final; held until handshake.

## Operation
- Nr = 10; with `AES_KEYLEN_SEL_EN`: 10/12/14 for `key_len` 0/1/2, latched at accept and constant for that block.
- FSM states: IDLE, LOAD, ROUND, HOLD.
- IDLE: when `start`=1, capture `text_in` into `text_in_r` and `key_len`, then go to LOAD. Otherwise stay.
- LOAD (1 cycle): `ld_r`=`kld`=1, `busy`=1. Next state is ROUND with `round_idx`=1.
- ROUND: `round_en`=1 and `round_idx` increments each cycle.
  - `last_round`=1 when `round_idx`==Nr; the next state is then HOLD and `round_idx` returns to 0.
  - `round_idx` never exceeds Nr and never wraps.
- HOLD: `out_valid`=1, `busy`=1, and the datapath is frozen (`round_en`=0).
  - On `out_valid`&&`out_ready`: if `start`=1 in the same cycle, capture the new block and go to LOAD (back-to-back); else go to IDLE.
- `start` in LOAD/ROUND, or in HOLD without `out_ready`, is ignored; there is no queueing.
- `text_in` changes outside the accept cycle have no effect.

## Timing
- Reset values: `text_in_r`=0, `ld_r`=`kld`=`round_en`=`last_round`=`busy`=`out_valid`=0, `round_idx`=0, state IDLE. The latched `key_len` resets to 0.
- `rst` asserted in any state aborts the block with no `out_valid`. Reset has priority over `start` and the handshake.
- With `start` accepted at cycle edge 0:
  - `ld_r`/`kld` are high in cycle 1.
  - `round_idx`=1..Nr in cycles 2..Nr+1.
  - `out_valid` rises in cycle Nr+2 (cycle 12 for Nr=10).
- Throughput with `out_ready` tied high and back-to-back `start`: one block per Nr+2 cycles.
- All outputs are registered (Moore); there are no combinational paths from inputs to outputs.

## Configuration
- `AES_KEYLEN_SEL_EN` defined: the `key_len` port exists and Nr is selectable as 10/12/14. `round_idx` reaches 14 maximum.
- Undefined: there is no `key_len` port, Nr is fixed at 10, and the key-length register is removed.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles with `start`=0.
- Single block, `text_in`=0x00112233445566778899aabbccddeeff, `out_ready`=1:
  - `text_in_r` matches the input from cycle 1.
  - `ld_r`/`kld` are high only in cycle 1.
  - `round_idx` is 1..10 in cycles 2..11, with `last_round` high only in cycle 11.
  - `out_valid` is high in cycle 12 for exactly one cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - `out_valid` stays high and `round_en`=0 throughout.
  - A `start` pulsed in HOLD is ignored.
  - Raising `out_ready` returns the FSM to IDLE.
- Back-to-back: `start`=1 in the handshake cycle with a new block. `ld_r` occurs the next cycle and the new `text_in_r` is captured. Two results are produced 12 cycles apart.
- Mid-run reset: assert `rst` when `round_idx`=5.
  - The next cycle has all outputs 0 and the FSM in IDLE.
  - A following `start` completes normally.
- With `AES_KEYLEN_SEL_EN`:
  - `key_len`=2 gives `last_round` at `round_idx`=14 and `out_valid` in cycle 16.
  - `key_len`=3 behaves as Nr=10.
  - Changing `key_len` mid-block does not alter the running Nr.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: load strobe, round counter, final-round flag, valid/ready result hold; `AES_KEYLEN_SEL_EN adds key_len (Nr 10/12/14).
// Latency: ld_r one cycle after accept, round_idx 1..Nr next, out_valid Nr+2 cycles after accept.
// Backpressure: out_valid held until out_ready; start ignored while busy except in the handshake cycle.
module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] text_in,
`ifdef AES_KEYLEN_SEL_EN
    input  logic [1:0]   key_len,
`endif
    input  logic         out_ready,
    output logic [127:0] text_in_r,
    output logic         ld_r,
    output logic         kld,
    output logic [3:0]   round_idx,
    output logic         round_en,
    output logic         last_round,
    output logic         busy,
    output logic         out_valid
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_HOLD} state_t;

    state_t     r_state;
    logic [3:0] w_nr;
    logic       w_accept;

`ifdef AES_KEYLEN_SEL_EN
    logic [1:0] r_key_len;

    // Reserved encoding 3 falls back to AES-128.
    always_comb begin
        case (r_key_len)
            2'd1:    w_nr = 4'd12;
            2'd2:    w_nr = 4'd14;
            default: w_nr = 4'd10;
        endcase
    end
`else
    assign w_nr = 4'd10;
`endif

    assign w_accept = start && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            text_in_r  <= '0;
            ld_r       <= 1'b0;
            kld        <= 1'b0;
            round_idx  <= 4'd0;
            round_en   <= 1'b0;
            last_round <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
`ifdef AES_KEYLEN_SEL_EN
            r_key_len  <= 2'd0;
`endif
        end else begin
            ld_r <= 1'b0;
            kld  <= 1'b0;
            if (w_accept) begin
                text_in_r <= text_in;
`ifdef AES_KEYLEN_SEL_EN
                r_key_len <= key_len;
`endif
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        ld_r    <= 1'b1;
                        kld     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_ROUND;
                    round_idx  <= 4'd1;
                    round_en   <= 1'b1;
                    last_round <= 1'b0;
                end
                S_ROUND: begin
                    // last_round is registered, so it is set one step ahead of the final round.
                    if (round_idx == w_nr) begin
                        r_state    <= S_HOLD;
                        round_idx  <= 4'd0;
                        round_en   <= 1'b0;
                        last_round <= 1'b0;
                        out_valid  <= 1'b1;
                    end else begin
                        round_idx  <= round_idx + 4'd1;
                        last_round <= ((round_idx + 4'd1) == w_nr);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            r_state <= S_LOAD;
                            ld_r    <= 1'b1;
                            kld     <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
